// File: rtl/ode_pkg.sv
// Shared ODE interpolation RAM geometry and the RAM loader state encoding.
package ode_pkg;

  localparam int ODE_RAM_ADDRESS_WIDTH = 13;
  localparam int ODE_DATA_WIDTH        = 64;
  localparam int ODE_RAM_DEPTH         = 50;
  localparam int ODE_BUS_WIDTH         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/ode_beat_packer.sv
// Packs BUS_WIDTH beats LSB-first into one DATA_WIDTH word; flags the beat that completes it.
module ode_beat_packer #(
  parameter int BUS_WIDTH  = ode_pkg::ODE_BUS_WIDTH,
  parameter int DATA_WIDTH = ode_pkg::ODE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_valid,
  input  logic [BUS_WIDTH-1:0]  beat_data,
  output logic [DATA_WIDTH-1:0] pack_next,
  output logic                  word_full
);

  localparam int BEATS  = DATA_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0]     beat_q;
  logic [DATA_WIDTH-1:0] pack_q;

  assign word_full = beat_valid && (beat_q == BEAT_W'(BEATS - 1));

  // pack_next already contains the current beat so the loader can capture a complete word on the last handshake
  always_comb begin
    pack_next = pack_q;
    if (beat_valid) begin
      pack_next[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = beat_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      pack_q <= '0;
    end else if (beat_valid) begin
      pack_q <= pack_next;
      beat_q <= word_full ? '0 : beat_q + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/ode_ram_loader.sv
// Host-side writer that streams packed words into the shared interpolation RAM write port.
module ode_ram_loader #(
  parameter int RAM_ADDRESS_WIDTH = ode_pkg::ODE_RAM_ADDRESS_WIDTH,
  parameter int DATA_WIDTH        = ode_pkg::ODE_DATA_WIDTH,
  parameter int RAM_DEPTH         = ode_pkg::ODE_RAM_DEPTH,
  parameter int BUS_WIDTH         = ode_pkg::ODE_BUS_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Load_Start,
  input  logic [RAM_ADDRESS_WIDTH-1:0] Load_Base,
  input  logic [RAM_ADDRESS_WIDTH-1:0] Load_Count,
  input  logic [BUS_WIDTH-1:0]         In_Data,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  output logic                         Loader_Memory_WR_Enable,
  output logic [RAM_ADDRESS_WIDTH-1:0] Loader_RAM_WR_Address,
  output logic [DATA_WIDTH-1:0]        Loader_RAM_WR_Data,
  output logic                         Loader_Busy,
  output logic                         Load_Done,
  output logic                         Load_Error
);

  import ode_pkg::*;

  localparam logic [RAM_ADDRESS_WIDTH:0] DEPTH_LIMIT = (RAM_ADDRESS_WIDTH + 1)'(RAM_DEPTH);

  loader_state_t state, state_next;

  logic [RAM_ADDRESS_WIDTH-1:0] base_q;
  logic [RAM_ADDRESS_WIDTH-1:0] count_q;
  logic [RAM_ADDRESS_WIDTH-1:0] word_q;
  logic [RAM_ADDRESS_WIDTH:0]   end_sum;
  logic                         bad_request;
  logic                         accept_start;
  logic                         last_word;
  logic                         handshake;
  logic                         word_full;
  logic [DATA_WIDTH-1:0]        pack_next;

  // Widened by one bit so base+count near the top of the address space cannot wrap past the check
  assign end_sum      = {1'b0, Load_Base} + {1'b0, Load_Count};
  assign bad_request  = (Load_Count == '0) || (end_sum > DEPTH_LIMIT);
  assign accept_start = (state == IDLE) && Load_Start;
  assign last_word    = (word_q + RAM_ADDRESS_WIDTH'(1)) == count_q;
  assign handshake    = In_Valid && (state == RECV);

  assign In_Ready    = (state == RECV);
  assign Loader_Busy = (state != IDLE);

  ode_beat_packer #(
    .BUS_WIDTH  (BUS_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (CLK),
    .rst_n      (RST),
    .beat_valid (handshake),
    .beat_data  (In_Data),
    .pack_next  (pack_next),
    .word_full  (word_full)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Load_Start) state_next = bad_request ? DONE : RECV;
      RECV:    if (word_full) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : RECV;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from state_next so they line up exactly with the WRITE and DONE cycles
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      base_q                  <= '0;
      count_q                 <= '0;
      word_q                  <= '0;
      Loader_Memory_WR_Enable <= 1'b0;
      Loader_RAM_WR_Address   <= '0;
      Loader_RAM_WR_Data      <= '0;
      Load_Done               <= 1'b0;
      Load_Error              <= 1'b0;
    end else begin
      if (accept_start) begin
        base_q  <= Load_Base;
        count_q <= Load_Count;
        word_q  <= '0;
      end else if (state == WRITE) begin
        word_q <= word_q + RAM_ADDRESS_WIDTH'(1);
      end
      Loader_Memory_WR_Enable <= (state_next == WRITE);
      if (state_next == WRITE) begin
        Loader_RAM_WR_Address <= base_q + word_q;
        Loader_RAM_WR_Data    <= pack_next;
      end
      Load_Done  <= (state_next == DONE);
      Load_Error <= accept_start && bad_request;
    end
  end

endmodule

// File: tb/tb_ode_ram_loader.sv
// Directed bench for ode_ram_loader: expected RAM writes are queued as stimulus is driven and checked as strobes appear.
module tb_ode_ram_loader;

  logic        CLK;
  logic        RST;
  logic        Load_Start;
  logic [12:0] Load_Base;
  logic [12:0] Load_Count;
  logic [15:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic        Loader_Memory_WR_Enable;
  logic [12:0] Loader_RAM_WR_Address;
  logic [63:0] Loader_RAM_WR_Data;
  logic        Loader_Busy;
  logic        Load_Done;
  logic        Load_Error;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cycles[$];
  wr_t mon_e;

  int errors;
  int checks;
  int cyc;
  int start_cyc;
  int write_count;
  int done_count;
  logic last_err;
  int wc0;
  int dc0;

  ode_ram_loader dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .Load_Start              (Load_Start),
    .Load_Base               (Load_Base),
    .Load_Count              (Load_Count),
    .In_Data                 (In_Data),
    .In_Valid                (In_Valid),
    .In_Ready                (In_Ready),
    .Loader_Memory_WR_Enable (Loader_Memory_WR_Enable),
    .Loader_RAM_WR_Address   (Loader_RAM_WR_Address),
    .Loader_RAM_WR_Data      (Loader_RAM_WR_Data),
    .Loader_Busy             (Loader_Busy),
    .Load_Done               (Load_Done),
    .Load_Error              (Load_Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation
  always @(negedge CLK) begin
    if (Loader_Memory_WR_Enable === 1'b1) begin
      write_count++;
      wr_cycles.push_back(cyc - start_cyc);
      checkOutput("ready_in_write", 64'(In_Ready), 64'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 64'(Loader_RAM_WR_Address), 64'(mon_e.addr));
        checkOutput("wr_data", Loader_RAM_WR_Data, mon_e.data);
      end
    end
    if (Load_Done === 1'b1) begin
      done_count++;
      last_err = Load_Error;
    end
  end

  task automatic push_expected(input logic [12:0] b, input logic [12:0] c, input logic [15:0] v0, input logic [15:0] step);
    wr_t e;
    for (int w = 0; w < int'(c); w++) begin
      e.addr = 13'(int'(b) + w);
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
        e.data[k*16 +: 16] = v0 + 16'(int'(step) * (w * 4 + k));
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic start_load(input logic [12:0] b, input logic [12:0] c);
    Load_Base  = b;
    Load_Count = c;
    Load_Start = 1'b1;
    start_cyc  = cyc;
    @(posedge CLK);
    #1;
    Load_Start = 1'b0;
    Load_Base  = 13'h1fff;
    Load_Count = 13'h1fff;
  endtask

  task automatic send_beat(input logic [15:0] d, input bit gap);
    bit accepted;
    logic rdy;
    accepted = 1'b0;
    if (gap) begin
      In_Valid = 1'b0;
      @(posedge CLK);
      #1;
    end
    In_Valid = 1'b1;
    In_Data  = d;
    for (int t = 0; t < 100 && !accepted; t++) begin
      @(negedge CLK);
      rdy = In_Ready;
      @(posedge CLK);
      #1;
      accepted = rdy;
    end
    checkOutput("beat_accept", 64'(accepted), 64'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge CLK);
      seen = (Load_Done === 1'b1);
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] b, input logic [12:0] c, input logic [15:0] v0, input logic [15:0] step, input bit gap);
    push_expected(b, c, v0, step);
    start_load(b, c);
    for (int i = 0; i < int'(c) * 4; i++) begin
      send_beat(v0 + 16'(int'(step) * i), gap);
    end
    In_Valid = 1'b0;
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_data"}, Loader_RAM_WR_Data, 64'd0);
    checkOutput({tag, "_ctrl"},
                64'({In_Ready, Loader_Memory_WR_Enable, Loader_RAM_WR_Address, Loader_Busy, Load_Done, Load_Error}),
                64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    start_cyc   = 0;
    write_count = 0;
    done_count  = 0;
    last_err    = 1'b0;
    RST         = 1'b0;
    Load_Start  = 1'b0;
    Load_Base   = '0;
    Load_Count  = '0;
    In_Data     = '0;
    In_Valid    = 1'b0;

    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] reset in the middle of a word");
    start_load(13'd0, 13'd1);
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b0);
    In_Valid = 1'b0;
    RST = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    wc0 = write_count;
    dc0 = done_count;
    repeat (8) @(posedge CLK);
    #1;
    checkOutput("no_write_after_reset", 64'(write_count), 64'(wc0));
    checkOutput("no_done_after_reset", 64'(done_count), 64'(dc0));
    checkOutput("idle_after_reset", 64'(Loader_Busy), 64'd0);
    applyStimulus(13'd0, 13'd1, 16'h1111, 16'h1111, 1'b0);
    checkOutput("fresh_write_count", 64'(write_count - wc0), 64'd1);

    $display("[TB] basic load");
    wr_cycles.delete();
    wc0 = write_count;
    dc0 = done_count;
    applyStimulus(13'd5, 13'd2, 16'h0001, 16'h0001, 1'b0);
    checkOutput("basic_writes", 64'(write_count - wc0), 64'd2);
    checkOutput("basic_strobe_count", 64'(wr_cycles.size()), 64'd2);
    checkOutput("basic_strobe0_cycle", 64'(wr_cycles[0]), 64'd5);
    checkOutput("basic_strobe1_cycle", 64'(wr_cycles[1]), 64'd10);
    checkOutput("basic_done", 64'(done_count - dc0), 64'd1);
    checkOutput("basic_error", 64'(last_err), 64'd0);

    $display("[TB] backpressure load");
    wc0 = write_count;
    dc0 = done_count;
    applyStimulus(13'd5, 13'd2, 16'h0001, 16'h0001, 1'b1);
    checkOutput("bp_writes", 64'(write_count - wc0), 64'd2);
    checkOutput("bp_done", 64'(done_count - dc0), 64'd1);
    checkOutput("bp_error", 64'(last_err), 64'd0);

    $display("[TB] top-of-RAM load");
    wc0 = write_count;
    applyStimulus(13'd48, 13'd2, 16'h0100, 16'h0003, 1'b0);
    checkOutput("top_writes", 64'(write_count - wc0), 64'd2);
    checkOutput("top_error", 64'(last_err), 64'd0);

    $display("[TB] out-of-range request");
    wc0 = write_count;
    start_load(13'd49, 13'd2);
    @(negedge CLK);
    checkOutput("range_done_error", 64'({Load_Done, Load_Error}), 64'd3);
    @(posedge CLK);
    #1;
    checkOutput("range_no_write", 64'(write_count - wc0), 64'd0);
    checkOutput("range_idle", 64'({Loader_Busy, Load_Done, Load_Error}), 64'd0);

    $display("[TB] zero-count request");
    start_load(13'd3, 13'd0);
    @(negedge CLK);
    checkOutput("zero_done_error", 64'({Load_Done, Load_Error}), 64'd3);
    @(posedge CLK);
    #1;
    checkOutput("zero_no_write", 64'(write_count - wc0), 64'd0);

    $display("[TB] start while busy");
    wc0 = write_count;
    dc0 = done_count;
    push_expected(13'd10, 13'd1, 16'h0A00, 16'h0001);
    start_load(13'd10, 13'd1);
    send_beat(16'h0A00, 1'b0);
    In_Valid   = 1'b0;
    Load_Base  = 13'd0;
    Load_Count = 13'd1;
    Load_Start = 1'b1;
    @(posedge CLK);
    #1;
    Load_Start = 1'b0;
    send_beat(16'h0A01, 1'b0);
    send_beat(16'h0A02, 1'b0);
    send_beat(16'h0A03, 1'b0);
    In_Valid = 1'b0;
    wait_done();
    repeat (10) @(posedge CLK);
    #1;
    checkOutput("busy_writes", 64'(write_count - wc0), 64'd1);
    checkOutput("busy_done", 64'(done_count - dc0), 64'd1);

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
